pe_layer: RTL and testbench

- One row of a weight/operand systolic array: M=5 multiply-accumulate processing elements (PEs) chained horizontally.
- Operand A enters PE0 and shifts right one PE per cycle. Each PE j takes its own vertical operand B_j and forwards it downward.
- Each PE keeps an N-bit accumulator. The accumulator can be cleared, preloaded or read out through the vertical output, one PE at a time.
- Instances stack vertically to form the full array.

---
 rtl/pe_layer_if.sv | 24 ++
 rtl/pe_layer.sv | 87 ++++++++
 tb/tb_pe_layer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pe_layer_if.sv
// Operand/control bundle for one systolic row: per-PE control vectors,
// horizontal A operand and five vertical B lanes in and out.
interface pe_layer_if #(
  parameter int N = 32,
  parameter int M = 5
);
  logic [M-1:0] clr;
  logic [M-1:0] read;
  logic [M-1:0] write;
  logic [N-1:0] A0;
  logic [N-1:0] B0, B1, B2, B3, B4;
  logic [N-1:0] A0_out;
  logic [N-1:0] B0_out, B1_out, B2_out, B3_out, B4_out;

  modport master (
    output clr, read, write, A0, B0, B1, B2, B3, B4,
    input  A0_out, B0_out, B1_out, B2_out, B3_out, B4_out
  );

  modport slave (
    input  clr, read, write, A0, B0, B1, B2, B3, B4,
    output A0_out, B0_out, B1_out, B2_out, B3_out, B4_out
  );
endinterface

// File: rtl/pe_layer.sv
// One row of five MAC processing elements; A shifts right, B passes down.
// Define ACC_SAT_EN for a saturating accumulator instead of modulo-2^N wrap.
module pe_layer #(
  parameter int N = 32,
  parameter int M = 5
) (
  input logic       clk,
  input logic       clr_n,
  pe_layer_if.slave bus
);

  logic [N-1:0] w_b    [M];
  logic [N-1:0] w_a_in [M];
  logic [N-1:0] r_a    [M];
  logic [N-1:0] r_b    [M];
  logic [N-1:0] r_acc  [M];

  function automatic logic [N-1:0] mac_next(
    input logic [N-1:0] acc,
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
`ifdef ACC_SAT_EN
    logic [2*N-1:0] prod;
    logic [2*N:0]   sum;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    sum  = {1'b0, prod} + {{(N+1){1'b0}}, acc};
    if (|sum[2*N:N]) begin
      return {N{1'b1}};
    end else begin
      return sum[N-1:0];
    end
`else
    logic [N-1:0] prod;
    prod = a * b;
    return acc + prod;
`endif
  endfunction

  // Gather the vertical lanes and build the A chain seen by each PE
  always_comb begin
    w_b[0] = bus.B0;
    w_b[1] = bus.B1;
    w_b[2] = bus.B2;
    w_b[3] = bus.B3;
    w_b[4] = bus.B4;
    w_a_in[0] = bus.A0;
    for (int j = 1; j < M; j++) begin
      w_a_in[j] = r_a[j-1];
    end
  end

  assign bus.A0_out = r_a[M-1];
  assign bus.B0_out = r_b[0];
  assign bus.B1_out = r_b[1];
  assign bus.B2_out = r_b[2];
  assign bus.B3_out = r_b[3];
  assign bus.B4_out = r_b[4];

  // Per-PE state: clear beats preload beats MAC; readout samples the pre-edge accumulator
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int j = 0; j < M; j++) begin
        r_a[j]   <= '0;
        r_b[j]   <= '0;
        r_acc[j] <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        if (bus.clr[j]) begin
          r_a[j]   <= '0;
          r_b[j]   <= '0;
          r_acc[j] <= '0;
        end else begin
          r_a[j] <= w_a_in[j];
          r_b[j] <= bus.read[j] ? r_acc[j] : w_b[j];
          if (bus.write[j]) begin
            r_acc[j] <= w_b[j];
          end else begin
            r_acc[j] <= mac_next(r_acc[j], w_a_in[j], w_b[j]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_layer.sv
// Directed bench for pe_layer: stimulus pushes hand-computed expected outputs,
// a monitor pops and compares them against the live outputs.
module tb_pe_layer;

  typedef struct {
    string             tag;
    logic [5:0][31:0]  exp;
  } exp_t;

  logic clk;
  logic clr_n;
  exp_t sb_q[$];
  event mon_ev;
  int   n_checks;
  int   n_errors;

  pe_layer_if #(.N(32), .M(5)) bus();

  pe_layer #(.N(32), .M(5)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare every queued expectation against the current outputs
  initial begin
    logic [5:0][31:0] act;
    exp_t e;
    forever begin
      @(mon_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act[0] = bus.A0_out;
        act[1] = bus.B0_out;
        act[2] = bus.B1_out;
        act[3] = bus.B2_out;
        act[4] = bus.B3_out;
        act[5] = bus.B4_out;
        for (int k = 0; k < 6; k++) begin
          n_checks++;
          if (act[k] !== e.exp[k]) begin
            n_errors++;
            if (k == 0) begin
              $display("FAIL %s A0_out got=%h exp=%h", e.tag, act[k], e.exp[k]);
            end else begin
              $display("FAIL %s B%0d_out got=%h exp=%h", e.tag, k - 1, act[k], e.exp[k]);
            end
          end
        end
      end
    end
  end

  task automatic set_in(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] b1,
                        input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] b4,
                        input logic [4:0] c, input logic [4:0] r, input logic [4:0] w);
    bus.A0 = a0;
    bus.B0 = b0;
    bus.B1 = b1;
    bus.B2 = b2;
    bus.B3 = b3;
    bus.B4 = b4;
    bus.clr = c;
    bus.read = r;
    bus.write = w;
  endtask

  task automatic expect_now(input string tag, input logic [31:0] ea, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3, input logic [31:0] e4);
    exp_t e;
    e.tag = tag;
    e.exp[0] = ea;
    e.exp[1] = e0;
    e.exp[2] = e1;
    e.exp[3] = e2;
    e.exp[4] = e3;
    e.exp[5] = e4;
    sb_q.push_back(e);
    ->mon_ev;
  endtask

  // One rising edge, then publish what the outputs must be just after it
  task automatic step(input string tag, input logic [31:0] ea, input logic [31:0] e0,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] e3, input logic [31:0] e4);
    @(posedge clk);
    #1;
    expect_now(tag, ea, e0, e1, e2, e3, e4);
  endtask

  initial begin
    logic [31:0] wrap_exp;
    logic [31:0] after_wrap;
`ifdef ACC_SAT_EN
    wrap_exp   = 32'hFFFF_FFFF;
    after_wrap = 32'hFFFF_FFFF;
`else
    wrap_exp   = 32'hFFFF_FFFE;
    after_wrap = 32'h0000_0001;
`endif
    n_checks = 0;
    n_errors = 0;
    clr_n = 1'b1;
    set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           5'($urandom), 5'($urandom), 5'($urandom));
    #2;
    clr_n = 1'b0;
    #1;
    expect_now("async_rst", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #4;
    clr_n = 1'b1;
    set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           5'b11111, 5'($urandom), 5'($urandom));
    step("clr_all", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // MAC pipeline, A0=3, B=1..5
    set_in(32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 5'b00000, 5'b00000, 5'b00000);
    step("mac_e1", 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    step("mac_e2", 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    step("mac_e3", 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    step("mac_e4", 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    step("mac_e5", 32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    step("mac_e6", 32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    bus.read = 5'b11111;
    step("read_e7", 32'd3, 32'd18, 32'd30, 32'd36, 32'd36, 32'd30);
    bus.read = 5'b00000;
    step("pass_e8", 32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);

    // Preload PE0, then resume MAC
    set_in(32'd3, 32'd100, 32'd2, 32'd3, 32'd4, 32'd5, 5'b00000, 5'b00000, 5'b00001);
    step("preload", 32'd3, 32'd100, 32'd2, 32'd3, 32'd4, 32'd5);
    set_in(32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 5'b00000, 5'b00000, 5'b00000);
    step("post_pre", 32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    bus.read = 5'b11111;
    step("read_pre", 32'd3, 32'd103, 32'd54, 32'd72, 32'd84, 32'd90);

    // Clear PE2 only; PE3 sees a one-cycle A bubble
    set_in(32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 5'b00100, 5'b00000, 5'b00000);
    step("clr_pe2", 32'd3, 32'd1, 32'd2, 32'd0, 32'd4, 32'd5);
    set_in(32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 5'b00000, 5'b11111, 5'b00000);
    step("read_clr", 32'd3, 32'd109, 32'd66, 32'd0, 32'd108, 32'd120);
    step("bubble", 32'd0, 32'd112, 32'd72, 32'd9, 32'd108, 32'd135);
    step("after_bub", 32'd3, 32'd115, 32'd78, 32'd18, 32'd120, 32'd135);

    // Wrap / saturate boundary
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'b11111, 5'b00000, 5'b00000);
    step("clr_wrap", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_in(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 5'b00000, 5'b00000);
    step("wrap_mac", 32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 5'b00001, 5'b00000);
    step("wrap_read", 32'd0, wrap_exp, 32'd0, 32'd0, 32'd0, 32'd0);

    // Mid-operation asynchronous reset
    set_in(32'd3, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 5'b00000, 5'b00000, 5'b00000);
    step("mid_e1", 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    bus.read = 5'b00001;
    step("mid_rd", 32'd0, after_wrap, 32'd2, 32'd3, 32'd4, 32'd5);
    bus.read = 5'b00000;
    clr_n = 1'b0;
    #1;
    expect_now("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    clr_n = 1'b1;
    step("restart1", 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    bus.read = 5'b11111;
    step("restart_rd", 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0);

    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
